// File: rtl/esdi_cmd_sequencer.sv
// rtl/esdi_cmd_sequencer.sv - ESDI command request to AXI-lite CSR transaction sequencer
module esdi_cmd_sequencer #(
    parameter int POLL_GAP   = 16,
    parameter int POLL_LIMIT = 65535
) (
    input  logic        csr_aclk,
    input  logic        csr_areset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_word,
    input  logic        req_query,
    input  logic        req_wait_cc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_data,
    output logic [3:0]  resp_status,
    output logic        ctl_awvalid,
    input  logic        ctl_awready,
    output logic [4:0]  ctl_awaddr,
    output logic [2:0]  ctl_awprot,
    output logic        ctl_wvalid,
    input  logic        ctl_wready,
    output logic [31:0] ctl_wdata,
    output logic [3:0]  ctl_wstrb,
    input  logic        ctl_bvalid,
    output logic        ctl_bready,
    input  logic [1:0]  ctl_bresp,
    output logic        ctl_arvalid,
    input  logic        ctl_arready,
    output logic [4:0]  ctl_araddr,
    output logic [2:0]  ctl_arprot,
    input  logic        ctl_rvalid,
    output logic        ctl_rready,
    input  logic [31:0] ctl_rdata,
    input  logic [1:0]  ctl_rresp
);

    localparam logic [4:0] A_STATUS = 5'h00;
    localparam logic [4:0] A_DATA   = 5'h04;
    localparam logic [4:0] A_LINES  = 5'h10;

    localparam int CW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [CW-1:0] POLL_LAST = CW'(POLL_LIMIT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_GAP, S_AW, S_B, S_DONE} state_t;
    typedef enum logic [1:0] {PH_TX, PH_RX, PH_DATA, PH_CC} phase_t;

    state_t          r_state;
    phase_t          r_phase;
    logic            r_req_ready;
    logic            r_resp_valid;
    logic [15:0]     r_resp_data;
    logic [3:0]      r_resp_status;
    logic            r_arvalid;
    logic [4:0]      r_araddr;
    logic            r_rready;
    logic            r_awvalid;
    logic            r_wvalid;
    logic            r_bready;
    logic [15:0]     r_word;
    logic            r_query;
    logic            r_wait_cc;
    logic [CW-1:0]   r_poll_cnt;
    logic [GW-1:0]   r_gap_cnt;

    logic            w_poll_hit;
    logic            w_unused_rdata;

    assign w_unused_rdata = &{1'b0, ctl_rdata[31:18]};

    always_comb begin
        w_poll_hit = 1'b0;
        case (r_phase)
            PH_TX:   w_poll_hit = ~ctl_rdata[0];
            PH_RX:   w_poll_hit = ctl_rdata[1];
            PH_CC:   w_poll_hit = ~ctl_rdata[2];
            default: w_poll_hit = 1'b0;
        endcase
    end

    always_ff @(posedge csr_aclk) begin
        if (csr_areset) begin
            r_state       <= S_IDLE;
            r_phase       <= PH_TX;
            r_req_ready   <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_data   <= '0;
            r_resp_status <= '0;
            r_arvalid     <= 1'b0;
            r_araddr      <= A_STATUS;
            r_rready      <= 1'b0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_word        <= '0;
            r_query       <= 1'b0;
            r_wait_cc     <= 1'b0;
            r_poll_cnt    <= '0;
            r_gap_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_req_ready   <= 1'b0;
                        r_word        <= req_word;
                        r_query       <= req_query;
                        r_wait_cc     <= req_wait_cc;
                        r_resp_data   <= '0;
                        r_resp_status <= '0;
                        r_phase       <= PH_TX;
                        r_poll_cnt    <= '0;
                        r_araddr      <= A_STATUS;
                        r_arvalid     <= 1'b1;
                        r_state       <= S_AR;
                    end else begin
                        r_req_ready   <= ~r_resp_valid;
                    end
                end
                S_AR: begin
                    if (ctl_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_R;
                    end
                end
                S_R: begin
                    if (ctl_rvalid) begin
                        r_rready <= 1'b0;
                        if (ctl_rresp != 2'b00) begin
                            r_resp_status[3] <= 1'b1;
                            r_resp_valid     <= 1'b1;
                            r_state          <= S_DONE;
                        end else if (r_phase == PH_DATA) begin
                            r_resp_data      <= ctl_rdata[15:0];
                            r_resp_status[0] <= ctl_rdata[16];
                            r_resp_status[1] <= ctl_rdata[17];
                            if (r_wait_cc) begin
                                r_phase    <= PH_CC;
                                r_poll_cnt <= '0;
                                r_araddr   <= A_LINES;
                                r_arvalid  <= 1'b1;
                                r_state    <= S_AR;
                            end else begin
                                r_resp_valid <= 1'b1;
                                r_state      <= S_DONE;
                            end
                        end else if (w_poll_hit) begin
                            case (r_phase)
                                PH_TX: begin
                                    r_awvalid <= 1'b1;
                                    r_wvalid  <= 1'b1;
                                    r_state   <= S_AW;
                                end
                                PH_RX: begin
                                    r_phase   <= PH_DATA;
                                    r_araddr  <= A_DATA;
                                    r_arvalid <= 1'b1;
                                    r_state   <= S_AR;
                                end
                                default: begin
                                    r_resp_valid <= 1'b1;
                                    r_state      <= S_DONE;
                                end
                            endcase
                        end else if (r_poll_cnt == POLL_LAST) begin
                            r_resp_status[2] <= 1'b1;
                            r_resp_valid     <= 1'b1;
                            r_state          <= S_DONE;
                        end else begin
                            // Repoll the same address, spaced by POLL_GAP idle cycles
                            r_poll_cnt <= r_poll_cnt + 1'b1;
                            if (POLL_GAP == 0) begin
                                r_arvalid <= 1'b1;
                                r_state   <= S_AR;
                            end else begin
                                r_gap_cnt <= '0;
                                r_state   <= S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_arvalid <= 1'b1;
                        r_state   <= S_AR;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                S_AW: begin
                    if (ctl_awready) r_awvalid <= 1'b0;
                    if (ctl_wready)  r_wvalid  <= 1'b0;
                    if ((!r_awvalid || ctl_awready) && (!r_wvalid || ctl_wready)) begin
                        r_bready <= 1'b1;
                        r_state  <= S_B;
                    end
                end
                S_B: begin
                    if (ctl_bvalid) begin
                        r_bready <= 1'b0;
                        if (ctl_bresp != 2'b00) begin
                            r_resp_status[3] <= 1'b1;
                            r_resp_valid     <= 1'b1;
                            r_state          <= S_DONE;
                        end else if (r_query) begin
                            r_phase    <= PH_RX;
                            r_poll_cnt <= '0;
                            r_araddr   <= A_STATUS;
                            r_arvalid  <= 1'b1;
                            r_state    <= S_AR;
                        end else if (r_wait_cc) begin
                            r_phase    <= PH_CC;
                            r_poll_cnt <= '0;
                            r_araddr   <= A_LINES;
                            r_arvalid  <= 1'b1;
                            r_state    <= S_AR;
                        end else begin
                            r_resp_valid <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_data   = r_resp_data;
    assign resp_status = r_resp_status;
    assign ctl_awvalid = r_awvalid;
    assign ctl_awaddr  = A_DATA;
    assign ctl_awprot  = 3'b000;
    assign ctl_wvalid  = r_wvalid;
    assign ctl_wdata   = {15'h0000, r_query, r_word};
    assign ctl_wstrb   = 4'hF;
    assign ctl_bready  = r_bready;
    assign ctl_arvalid = r_arvalid;
    assign ctl_araddr  = r_araddr;
    assign ctl_arprot  = 3'b000;
    assign ctl_rready  = r_rready;

endmodule

// File: tb/tb_esdi_cmd_sequencer.sv
// tb/tb_esdi_cmd_sequencer.sv - randomized self-checking bench for esdi_cmd_sequencer
module tb_esdi_cmd_sequencer;

    localparam int GAP = 2;
    localparam int LIM = 4;

    logic        csr_aclk = 1'b0;
    logic        csr_areset;
    logic        req_valid, req_ready, req_query, req_wait_cc;
    logic [15:0] req_word;
    logic        resp_valid, resp_ready;
    logic [15:0] resp_data;
    logic [3:0]  resp_status;
    logic        ctl_awvalid, ctl_awready, ctl_wvalid, ctl_wready;
    logic [4:0]  ctl_awaddr, ctl_araddr;
    logic [2:0]  ctl_awprot, ctl_arprot;
    logic [31:0] ctl_wdata, ctl_rdata;
    logic [3:0]  ctl_wstrb;
    logic        ctl_bvalid, ctl_bready, ctl_arvalid, ctl_arready, ctl_rvalid, ctl_rready;
    logic [1:0]  ctl_bresp, ctl_rresp;

    always #5 csr_aclk = ~csr_aclk;

    esdi_cmd_sequencer #(.POLL_GAP(GAP), .POLL_LIMIT(LIM)) dut (
        .csr_aclk(csr_aclk), .csr_areset(csr_areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_word(req_word),
        .req_query(req_query), .req_wait_cc(req_wait_cc),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_status(resp_status),
        .ctl_awvalid(ctl_awvalid), .ctl_awready(ctl_awready), .ctl_awaddr(ctl_awaddr),
        .ctl_awprot(ctl_awprot), .ctl_wvalid(ctl_wvalid), .ctl_wready(ctl_wready),
        .ctl_wdata(ctl_wdata), .ctl_wstrb(ctl_wstrb), .ctl_bvalid(ctl_bvalid),
        .ctl_bready(ctl_bready), .ctl_bresp(ctl_bresp), .ctl_arvalid(ctl_arvalid),
        .ctl_arready(ctl_arready), .ctl_araddr(ctl_araddr), .ctl_arprot(ctl_arprot),
        .ctl_rvalid(ctl_rvalid), .ctl_rready(ctl_rready), .ctl_rdata(ctl_rdata),
        .ctl_rresp(ctl_rresp)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Slave script, written only by the stimulus process
    int          cfg_tx_busy, cfg_rx_empty, cfg_cc_busy;
    logic [31:0] cfg_rd_word;
    logic        cfg_b_err;
    logic        cfg_hold_w = 1'b0;
    int          req_seq = 0;

    // Slave state and observations, written only by the slave process
    int          cyc = 0, seen_seq = 0;
    int          c00, c04, c10, cbad, caw, tx_seen, rx_seen, cc_seen;
    int          gap_n, gap_min, gap_max, rfire_cyc, rdelay;
    logic [31:0] l_wdata, s_rdata;
    logic [4:0]  l_awaddr;
    logic        s_wrote, s_rpend, s_rfire, s_bfire, s_aw_got, s_w_got;
    logic        s_prev_ar, s_pend_miss, s_last_miss;

    always @(negedge csr_aclk) begin
        cyc = cyc + 1;
        if (csr_areset) begin
            ctl_arready = 0; ctl_rvalid = 0; ctl_awready = 0; ctl_wready = 0; ctl_bvalid = 0;
            ctl_rdata = 0; ctl_rresp = 0; ctl_bresp = 0;
            s_rpend = 0; s_rfire = 0; s_bfire = 0; s_aw_got = 0; s_w_got = 0;
            s_prev_ar = 0; s_last_miss = 0; s_pend_miss = 0;
        end else begin
            if (seen_seq != req_seq) begin
                seen_seq = req_seq;
                c00 = 0; c04 = 0; c10 = 0; cbad = 0; caw = 0;
                tx_seen = 0; rx_seen = 0; cc_seen = 0;
                gap_n = 0; gap_min = 9999; gap_max = -1;
                s_wrote = 0; s_last_miss = 0; l_wdata = 0; l_awaddr = 0;
            end
            if (ctl_arready) ctl_arready = 0;
            if (ctl_awready) ctl_awready = 0;
            if (ctl_wready)  ctl_wready  = 0;
            if (s_rfire) begin ctl_rvalid = 0; s_rfire = 0; end
            if (s_bfire) begin ctl_bvalid = 0; s_bfire = 0; s_aw_got = 0; s_w_got = 0; end
            // Idle cycles from a missed poll's R handshake to the next AR
            if (ctl_arvalid && !s_prev_ar && s_last_miss) begin
                gap_n++;
                if (cyc - rfire_cyc - 1 < gap_min) gap_min = cyc - rfire_cyc - 1;
                if (cyc - rfire_cyc - 1 > gap_max) gap_max = cyc - rfire_cyc - 1;
            end
            s_prev_ar = ctl_arvalid;
            if (s_rpend && !ctl_rvalid) begin
                if (rdelay == 0) begin ctl_rvalid = 1; ctl_rdata = s_rdata; ctl_rresp = 0; end
                else rdelay--;
            end
            if (ctl_rvalid && ctl_rready && !s_rfire) begin
                s_rfire = 1; s_rpend = 0; s_last_miss = s_pend_miss; rfire_cyc = cyc;
            end
            if (ctl_arvalid && !s_rpend && ($urandom_range(1, 0) == 1)) begin
                ctl_arready = 1; s_rpend = 1; rdelay = $urandom_range(2, 0);
                case (ctl_araddr)
                    5'h00: begin
                        c00++;
                        if (!s_wrote) begin
                            s_pend_miss = (tx_seen < cfg_tx_busy); tx_seen++;
                            s_rdata = {31'h0, s_pend_miss};
                        end else begin
                            s_pend_miss = (rx_seen < cfg_rx_empty); rx_seen++;
                            s_rdata = {30'h0, ~s_pend_miss, 1'b0};
                        end
                    end
                    5'h04: begin c04++; s_pend_miss = 0; s_rdata = cfg_rd_word; end
                    5'h10: begin
                        c10++; s_pend_miss = (cc_seen < cfg_cc_busy); cc_seen++;
                        s_rdata = ($urandom() & 32'hFFFF_FFFB) | {29'h0, s_pend_miss, 2'b00};
                    end
                    default: begin cbad++; s_pend_miss = 0; s_rdata = 32'hDEAD_BEEF; end
                endcase
            end
            if (s_aw_got && s_w_got && !ctl_bvalid && !s_bfire) begin
                ctl_bvalid = 1; ctl_bresp = cfg_b_err ? 2'b10 : 2'b00;
            end
            if (ctl_bvalid && ctl_bready && !s_bfire) s_bfire = 1;
            if (ctl_awvalid && !s_aw_got && !cfg_hold_w && ($urandom_range(1, 0) == 1)) begin
                ctl_awready = 1; s_aw_got = 1; caw++; l_awaddr = ctl_awaddr;
            end
            if (ctl_wvalid && !s_w_got && !cfg_hold_w && ($urandom_range(1, 0) == 1)) begin
                ctl_wready = 1; s_w_got = 1; s_wrote = 1; l_wdata = ctl_wdata;
            end
        end
    end

    // Expected outcome from the request rules: polls per phase, errors abort, timeouts at LIM
    task automatic ref_model(input logic q, input logic wcc, input int txb, input int rxe,
                             input int ccb, input logic [31:0] rdw, input logic berr,
                             output logic [15:0] d, output logic [3:0] st,
                             output int ntx, output int nrx, output int n04,
                             output int ncc, output int naw);
        d = 0; st = 0; ntx = 0; nrx = 0; n04 = 0; ncc = 0; naw = 0;
        if (txb >= LIM) begin ntx = LIM; st[2] = 1; return; end
        ntx = txb + 1; naw = 1;
        if (berr) begin st[3] = 1; return; end
        if (q) begin
            if (rxe >= LIM) begin nrx = LIM; st[2] = 1; return; end
            nrx = rxe + 1; n04 = 1;
            d = rdw[15:0]; st[0] = rdw[16]; st[1] = rdw[17];
        end
        if (wcc) begin
            if (ccb >= LIM) begin ncc = LIM; st[2] = 1; end
            else ncc = ccb + 1;
        end
    endtask

    task automatic run_req(input logic [15:0] word, input logic q, input logic wcc,
                           input int txb, input int rxe, input int ccb,
                           input logic [31:0] rdw, input logic berr, input int hold);
        logic [15:0] ed;
        logic [3:0]  est;
        int ntx, nrx, n04, ncc, naw, repolls, t;
        logic        stable;
        ref_model(q, wcc, txb, rxe, ccb, rdw, berr, ed, est, ntx, nrx, n04, ncc, naw);
        repolls = ((ntx > 0) ? ntx - 1 : 0) + ((nrx > 0) ? nrx - 1 : 0) + ((ncc > 0) ? ncc - 1 : 0);
        cfg_tx_busy = txb; cfg_rx_empty = rxe; cfg_cc_busy = ccb;
        cfg_rd_word = rdw; cfg_b_err = berr;
        t = 0;
        while (!req_ready && t < 200) begin @(negedge csr_aclk); t++; end
        check("req_ready_wait", {31'h0, req_ready}, 32'h1);
        if (!req_ready) return;
        req_seq++;
        req_word = word; req_query = q; req_wait_cc = wcc; req_valid = 1;
        @(negedge csr_aclk);
        req_valid = 0;
        t = 0;
        while (!resp_valid && t < 3000) begin @(negedge csr_aclk); t++; end
        check("resp_valid_wait", {31'h0, resp_valid}, 32'h1);
        if (!resp_valid) return;
        stable = 1;
        for (int i = 0; i < hold; i++) begin
            @(negedge csr_aclk);
            if (!resp_valid || resp_data !== ed || resp_status !== est || req_ready) stable = 0;
        end
        if (hold > 0) check("resp_hold_stable", {31'h0, stable}, 32'h1);
        check("req_ready_during_resp", {31'h0, req_ready}, 32'h0);
        check("resp_data", {16'h0, resp_data}, {16'h0, ed});
        check("resp_status", {28'h0, resp_status}, {28'h0, est});
        resp_ready = 1;
        @(negedge csr_aclk);
        resp_ready = 0;
        check("rd_status_cnt", c00, ntx + nrx);
        check("rd_data_cnt", c04, n04);
        check("rd_lines_cnt", c10, ncc);
        check("rd_bad_addr", cbad, 0);
        check("aw_cnt", caw, naw);
        check("repoll_cnt", gap_n, repolls);
        if (gap_n > 0) begin
            check("poll_gap_min", gap_min, GAP);
            check("poll_gap_max", gap_max, GAP);
        end
        if (naw > 0) begin
            check("wdata", l_wdata, {15'h0, q, word});
            check("awaddr", {27'h0, l_awaddr}, 32'h4);
        end
    endtask

    initial begin
        int t;
        csr_areset = 1; req_valid = 0; req_word = 0; req_query = 0; req_wait_cc = 0; resp_ready = 0;
        cfg_tx_busy = 0; cfg_rx_empty = 0; cfg_cc_busy = 0; cfg_rd_word = 0; cfg_b_err = 0;
        repeat (3) @(negedge csr_aclk);
        check("rst_valids", {26'h0, ctl_arvalid, ctl_awvalid, ctl_wvalid, ctl_bready, ctl_rready, resp_valid}, 32'h0);
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("rst_resp", {12'h0, resp_status, resp_data}, 32'h0);
        check("const_prot_strb", {22'h0, ctl_awprot, ctl_arprot, ctl_wstrb}, 32'h0000_000F);
        csr_areset = 0;

        run_req(16'h1234, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        run_req(16'hA001, 1, 0, 0, 3, 0, 32'h0000_5A5A, 0, 0);
        run_req(16'h0042, 1, 0, 0, 0, 0, 32'h0002_0000, 0, 0);
        run_req(16'h0043, 1, 0, 0, 1, 0, 32'h0001_5A5A, 0, 0);
        run_req(16'h0055, 0, 0, 100, 0, 0, 32'h0, 0, 0);
        run_req(16'h0300, 0, 1, 0, 0, 2, 32'h0, 0, 0);
        run_req(16'h0301, 1, 1, 0, 0, 0, 32'h0000_0001, 1, 0);
        run_req(16'h7777, 0, 0, 1, 0, 0, 32'h0, 0, 5);

        // Reset while the write address/data are stalled by the slave
        cfg_tx_busy = 0; cfg_hold_w = 1;
        t = 0;
        while (!req_ready && t < 200) begin @(negedge csr_aclk); t++; end
        req_seq++;
        req_word = 16'hBEEF; req_query = 0; req_wait_cc = 0; req_valid = req_ready;
        @(negedge csr_aclk);
        req_valid = 0;
        t = 0;
        while (!ctl_awvalid && t < 200) begin @(negedge csr_aclk); t++; end
        check("awvalid_before_reset", {31'h0, ctl_awvalid}, 32'h1);
        csr_areset = 1;
        @(negedge csr_aclk);
        check("midreset_valids", {26'h0, ctl_arvalid, ctl_awvalid, ctl_wvalid, ctl_bready, ctl_rready, resp_valid}, 32'h0);
        check("midreset_req_ready", {31'h0, req_ready}, 32'h0);
        csr_areset = 0; cfg_hold_w = 0;
        @(negedge csr_aclk);
        check("postreset_req_ready", {31'h0, req_ready}, 32'h1);

        for (int i = 0; i < 40; i++) begin
            run_req(16'($urandom()), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                    $urandom_range(5, 0), $urandom_range(5, 0), $urandom_range(5, 0),
                    $urandom(), ($urandom_range(5, 0) == 0), $urandom_range(3, 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/esdi_cmd_sequencer.md
Name: esdi_cmd_sequencer

Overview:
- Upstream stage of the ESDI serial command controller. Turns stream-style command requests into AXI-lite master transactions on the controller's CSR block, then returns one response per request.
- Sequence per request: wait for TX buffer free, write word, poll for RX data on queries, read result, optionally wait for COMMAND COMPLETE.
- Sits between the host command engine or microcode and the CSR slave, so software no longer has to poll the serial controller.

Parameters:
- POLL_GAP, 16, idle cycles between consecutive status polls (0 = back-to-back).
- POLL_LIMIT, 65535, maximum polls per wait phase before a sequencer timeout.

Ports:
- csr_aclk  in  1  clock
- csr_areset  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_word  in  16  ESDI command word
- req_query  in  1  1 = configuration/status transfer (expects 16-bit reply)
- req_wait_cc  in  1  1 = after sending, wait for COMMAND COMPLETE
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed when valid&ready
- resp_data  out  16  reply word (0 for non-query)
- resp_status  out  4  [0] parity error, [1] drive handshake timeout, [2] poll timeout, [3] AXI error
- ctl_awvalid/ctl_awready/ctl_awaddr[4:0]/ctl_awprot[2:0]  AXI-lite master write address (awprot fixed 0)
- ctl_wvalid/ctl_wready/ctl_wdata[31:0]/ctl_wstrb[3:0]  AXI-lite master write data (wstrb fixed 4'hF)
- ctl_bvalid/ctl_bready/ctl_bresp[1:0]  AXI-lite master write response
- ctl_arvalid/ctl_arready/ctl_araddr[4:0]/ctl_arprot[2:0]  AXI-lite master read address (arprot fixed 0)
- ctl_rvalid/ctl_rready/ctl_rdata[31:0]/ctl_rresp[1:0]  AXI-lite master read data

Behaviour:
- Reset values: all ctl_*valid = 0, ctl_bready = ctl_rready = 0, resp_valid = 0, req_ready = 0, resp_data = 0, resp_status = 0, state = IDLE. Reset mid-transaction abandons it; the slave is reset by the same reset.
- Register map used:
  - 0x00 status: bit0 TX busy, bit1 RX valid.
  - 0x04 data: write {15'h0, query, word}; read {14'h0, timeout, parity_err, word}.
  - 0x10 lines: bit2 = COMMAND COMPLETE, active-low.
- IDLE: req_ready = 1 only in IDLE with resp_valid = 0. On accept, latch word/query/wait_cc, clear status, go to POLL_TX.
- POLL_TX: read 0x00 (AR then R). bit0 = 0 -> WRITE; else wait POLL_GAP cycles and repoll.
- WRITE: assert awvalid and wvalid in the same cycle; each drops independently on its own ready. Then assert bready until bvalid.
  - After WRITE: query -> POLL_RX; else wait_cc -> POLL_CC; else DONE.
- POLL_RX: read 0x00 until bit1 = 1 -> READ.
- READ: read 0x04. resp_data = rdata[15:0]; status[0] = rdata[16]; status[1] = rdata[17]. Then wait_cc -> POLL_CC, else DONE.
- POLL_CC: read 0x10 until bit2 = 0 -> DONE.
- Poll counter: cleared on entry to each poll state; increments per completed poll read. Reaching POLL_LIMIT without success sets status[2] and goes to DONE.
- AXI errors: any bresp/rresp != 0 sets status[3], aborts remaining phases and goes to DONE. The outstanding handshake is completed first.
- Only one AXI transaction is outstanding at a time. arvalid/awvalid/wvalid, once asserted, are held with stable address/data until ready (AXI rule). rready is asserted only while awaiting R.
- DONE: resp_valid = 1, outputs held stable until resp_ready; next cycle IDLE. Minimum request-to-response latency for a non-query is 4 AXI handshakes.
- Simultaneous resp_ready and a new req_valid: the request is not accepted in the same cycle. Accept occurs the following cycle at earliest.

Test Plan:
- Non-query 0x1234, slave TX idle -> one AR 0x00, one AW 0x04 with W 0x00001234, resp_valid with data 0, status 0.
- Query 0xA001, slave returns 0x00005A5A after 3 RX-empty polls -> AW W = 0x0001A001, 4 reads of 0x00 spaced POLL_GAP apart, read 0x04, resp_data 0x5A5A, status 0.
- Query where slave returns 0x00020000 -> resp_data 0, status 4'b0010. Separately, 0x00015A5A -> status 4'b0001.
- POLL_LIMIT = 4, TX stays busy -> exactly 4 polls, no AW issued, status 4'b0100.
- wait_cc command, 0x10 reads 0x4 twice then 0x0; bresp = SLVERR on a separate request -> first gives status 0 after 3 CC polls, second gives status 4'b1000 with no further reads.
- Reset asserted during WRITE with awvalid high -> next cycle all valids 0, req_ready 0; one cycle later req_ready 1. Also hold resp_ready = 0 for 5 cycles -> resp held stable, req_ready = 0.
